pid_sample_scheduler: RTL



---
 rtl/pid_sample_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pid_sample_scheduler.sv
// Time-multiplexes one PID compute core across NCH channels on a programmable sample tick,
// saving and restoring each channel's integrator/previous-error context around every job.
module pid_sample_scheduler #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned IW    = 16,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned TMO   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  sample_div,
    input  logic [NCH-1:0]    ch_enable,
    input  logic [NCH*DW-1:0] sp_in,
    input  logic [NCH*DW-1:0] fb_in,
    input  logic              overrun_clr,
    output logic              core_start,
    output logic [DW-1:0]     core_sp,
    output logic [DW-1:0]     core_fb,
    output logic [IW-1:0]     core_integ,
    output logic [DW-1:0]     core_perr,
    input  logic              core_done,
    input  logic [DW-1:0]     core_out,
    input  logic [IW-1:0]     core_integ_nx,
    input  logic [DW-1:0]     core_perr_nx,
    output logic [NCH*DW-1:0] ctrl_out,
    output logic [NCH-1:0]    out_valid,
    output logic [2:0]        cur_ch,
    output logic              overrun,
    output logic              fault
);
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0]    pending_q, pending_d, pend_clr;
    logic [2:0]        cur_ch_q, cur_ch_d, sel_ch;
    logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]     integ_q [NCH];
    logic [IW-1:0]     integ_d [NCH];
    logic [DW-1:0]     perr_q [NCH];
    logic [DW-1:0]     perr_d [NCH];
    logic [NCH*DW-1:0] ctrl_q, ctrl_d;
    logic [NCH-1:0]    valid_q, valid_d;
    logic              start_q, start_d;
    logic [DW-1:0]     sp_q, sp_d, fb_q, fb_d, perr_op_q, perr_op_d;
    logic [IW-1:0]     integ_op_q, integ_op_d;
    logic              overrun_q, overrun_d, fault_q, fault_d;
    logic              tick, done_evt, tmo_evt, busy;

    assign tick  = (cnt_q == sample_div);
    assign cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    assign busy  = (state_q == StIssue) || (state_q == StWait);

    // Lowest pending index wins.
    always_comb begin
        sel_ch = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_ch = 3'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        start_d    = 1'b0;
        done_evt   = 1'b0;
        tmo_evt    = 1'b0;
        wait_cnt_d = wait_cnt_q;
        sp_d       = sp_q;
        fb_d       = fb_q;
        integ_op_d = integ_op_q;
        perr_op_d  = perr_op_q;
        unique case (state_q)
            StIdle: begin
                if (pending_q != '0) begin
                    cur_ch_d = sel_ch;
                    start_d  = 1'b1;
                    state_d  = StIssue;
                    for (int i = 0; i < int'(NCH); i++) begin
                        if (sel_ch == 3'(i)) begin
                            sp_d       = sp_in[i*DW +: DW];
                            fb_d       = fb_in[i*DW +: DW];
                            integ_op_d = integ_q[i];
                            perr_op_d  = perr_q[i];
                        end
                    end
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // A done arriving on the last allowed cycle beats the timeout.
                if (core_done) begin
                    done_evt = 1'b1;
                    state_d  = StDone;
                end else if (wait_cnt_q == TW'(TMO - 1)) begin
                    tmo_evt = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pend_clr = '0;
        valid_d  = '0;
        ctrl_d   = ctrl_q;
        for (int i = 0; i < int'(NCH); i++) begin
            integ_d[i] = integ_q[i];
            perr_d[i]  = perr_q[i];
            if (cur_ch_q == 3'(i)) begin
                if (done_evt) begin
                    integ_d[i]           = core_integ_nx;
                    perr_d[i]            = core_perr_nx;
                    ctrl_d[i*DW +: DW]   = core_out;
                    valid_d[i]           = 1'b1;
                    pend_clr[i]          = 1'b1;
                end
                if (tmo_evt) pend_clr[i] = 1'b1;
            end
            // Anti-windup: idle disabled channels restart from a clean context.
            if (!ch_enable[i] && !(busy && cur_ch_q == 3'(i))) begin
                integ_d[i] = '0;
                perr_d[i]  = '0;
            end
        end
        pending_d = (pending_q & ~pend_clr) | (tick ? ch_enable : '0);
        overrun_d = overrun_q;
        if (tick && (pending_q != '0 || state_q != StIdle)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        fault_d = fault_q | tmo_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pending_q  <= '0;
            cur_ch_q   <= '0;
            wait_cnt_q <= '0;
            ctrl_q     <= '0;
            valid_q    <= '0;
            start_q    <= 1'b0;
            sp_q       <= '0;
            fb_q       <= '0;
            integ_op_q <= '0;
            perr_op_q  <= '0;
            overrun_q  <= 1'b0;
            fault_q    <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                integ_q[i] <= '0;
                perr_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            cur_ch_q   <= cur_ch_d;
            wait_cnt_q <= wait_cnt_d;
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            start_q    <= start_d;
            sp_q       <= sp_d;
            fb_q       <= fb_d;
            integ_op_q <= integ_op_d;
            perr_op_q  <= perr_op_d;
            overrun_q  <= overrun_d;
            fault_q    <= fault_d;
            for (int i = 0; i < int'(NCH); i++) begin
                integ_q[i] <= integ_d[i];
                perr_q[i]  <= perr_d[i];
            end
        end
    end

    assign core_start = start_q;
    assign core_sp    = sp_q;
    assign core_fb    = fb_q;
    assign core_integ = integ_op_q;
    assign core_perr  = perr_op_q;
    assign ctrl_out   = ctrl_q;
    assign out_valid  = valid_q;
    assign cur_ch     = cur_ch_q;
    assign overrun    = overrun_q;
    assign fault      = fault_q;

endmodule
